// File: rtl/sid_pkg.sv
// Shared constants and helpers for the SID voice oscillator: wave_sel bit
// positions, noise LFSR seed and the LFSR bits that form the 8-bit noise sample.
package sid_pkg;

  typedef logic [3:0] wave_sel_t;

  localparam logic [1:0] WS_TRI   = 2'd0;
  localparam logic [1:0] WS_SAW   = 2'd1;
  localparam logic [1:0] WS_PULSE = 2'd2;
  localparam logic [1:0] WS_NOISE = 2'd3;

  localparam int unsigned LFSR_W    = 32'd23;
  localparam logic [22:0] LFSR_SEED = 23'h7FFFF8;

  // Listed MSB first: entry 0 lands in noise sample bit 7
  localparam logic [4:0] NOISE_TAP_IDX [8] = '{5'd22, 5'd20, 5'd16, 5'd13,
                                               5'd11, 5'd7,  5'd4,  5'd2};

  function automatic logic [7:0] noise_pick(input logic [22:0] lfsr);
    noise_pick = 8'h00;
    for (int unsigned i = 32'd0; i < 32'd8; i++) begin
      noise_pick[~i[2:0]] = lfsr[NOISE_TAP_IDX[i[2:0]]];
    end
  endfunction

endpackage

// File: rtl/sid_noise_lfsr.sv
// 23-bit noise LFSR (feedback bit22^bit17). The tap output follows the
// post-update register value so the sample lines up with the new accumulator.
module sid_noise_lfsr
  import sid_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_i,
  input  logic       reload_i,
  output logic [7:0] noise_o
);

  logic [22:0] lfsr_q;
  logic [22:0] lfsr_d;

  // Reload beats shift; otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (reload_i) begin
      lfsr_d = LFSR_SEED;
    end else if (shift_i) begin
      lfsr_d = {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign noise_o = noise_pick(lfsr_d);

endmodule

// File: rtl/sid_voice_osc.sv
// SID-style voice oscillator: phase accumulator with hard sync, ring mod and test.
// Define SID_OSC_COMBINED_EN to AND multiple selected waveforms instead of priority select.
module sid_voice_osc
  import sid_pkg::*;
#(
  parameter int ACC_W     = 24,
  parameter int FREQ_W    = 16,
  parameter int PW_W      = 12,
  parameter int OUT_W     = 12,
  parameter int NOISE_BIT = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [FREQ_W-1:0] freq,
  input  logic [PW_W-1:0]   pw,
  input  wave_sel_t         wave_sel,
  input  logic              test,
  input  logic              sync_en,
  input  logic              ring_en,
  input  logic              sync_in,
  input  logic              ring_in,
  output logic              sync_out,
  output logic              msb_out,
  output logic [OUT_W-1:0]  wave_out
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic             sync_q;
  logic             sync_d;
  logic [OUT_W-1:0] wave_q;
  logic [OUT_W-1:0] wave_d;

  logic             noise_shift_s;
  logic             noise_reload_s;
  logic [7:0]       noise8_s;
  logic             tri_flip_s;
  logic [OUT_W-1:0] saw_s;
  logic [OUT_W-1:0] tri_s;
  logic [OUT_W-1:0] pulse_s;
  logic [OUT_W-1:0] noise_s;
  logic [OUT_W-1:0] mix_s;

  // Accumulator next value: test, then sync, then free-running add.
  always_comb begin
    acc_d = acc_q;
    if (tick) begin
      if (test) begin
        acc_d = {ACC_W{1'b0}};
      end else if (sync_en && sync_in) begin
        acc_d = {ACC_W{1'b0}};
      end else begin
        acc_d = acc_q + ACC_W'(freq);
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // A reset-to-zero can never raise the MSB, so sync/test cannot fire sync_out.
  always_comb begin
    sync_d = sync_q;
    if (tick) begin
      sync_d = acc_d[ACC_W-1] & ~acc_q[ACC_W-1];
    end else begin
      sync_d = sync_q;
    end
  end

  assign noise_shift_s  = tick & acc_d[NOISE_BIT] & ~acc_q[NOISE_BIT];
  assign noise_reload_s = tick & test;

  sid_noise_lfsr u_noise (
    .clk      (clk),
    .rst      (rst),
    .shift_i  (noise_shift_s),
    .reload_i (noise_reload_s),
    .noise_o  (noise8_s)
  );

  // Waveform generators driven from the post-update accumulator.
  always_comb begin
    saw_s      = acc_d[ACC_W-1 -: OUT_W];
    tri_flip_s = acc_d[ACC_W-1] ^ (ring_en & ring_in);
    tri_s      = acc_d[ACC_W-2 -: OUT_W] ^ {OUT_W{tri_flip_s}};
    if (test || (acc_d[ACC_W-1 -: PW_W] >= pw)) begin
      pulse_s = {OUT_W{1'b1}};
    end else begin
      pulse_s = {OUT_W{1'b0}};
    end
    noise_s = {OUT_W{1'b0}};
    noise_s[OUT_W-1 -: 8] = noise8_s;
  end

`ifdef SID_OSC_COMBINED_EN
  // Bitwise AND of every selected waveform.
  always_comb begin
    mix_s = {OUT_W{1'b1}};
    if (wave_sel[WS_NOISE]) begin
      mix_s = mix_s & noise_s;
    end else begin
      mix_s = mix_s;
    end
    if (wave_sel[WS_PULSE]) begin
      mix_s = mix_s & pulse_s;
    end else begin
      mix_s = mix_s;
    end
    if (wave_sel[WS_SAW]) begin
      mix_s = mix_s & saw_s;
    end else begin
      mix_s = mix_s;
    end
    if (wave_sel[WS_TRI]) begin
      mix_s = mix_s & tri_s;
    end else begin
      mix_s = mix_s;
    end
    if (wave_sel == 4'b0000) begin
      mix_s = {OUT_W{1'b0}};
    end else begin
      mix_s = mix_s;
    end
  end
`else
  // Highest selected waveform wins: noise > pulse > saw > tri.
  always_comb begin
    mix_s = {OUT_W{1'b0}};
    if (wave_sel[WS_NOISE]) begin
      mix_s = noise_s;
    end else if (wave_sel[WS_PULSE]) begin
      mix_s = pulse_s;
    end else if (wave_sel[WS_SAW]) begin
      mix_s = saw_s;
    end else if (wave_sel[WS_TRI]) begin
      mix_s = tri_s;
    end else begin
      mix_s = {OUT_W{1'b0}};
    end
  end
`endif

  // Output sample only refreshes on a tick.
  always_comb begin
    wave_d = wave_q;
    if (tick) begin
      wave_d = mix_s;
    end else begin
      wave_d = wave_q;
    end
  end

  // Oscillator state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= {ACC_W{1'b0}};
      sync_q <= 1'b0;
      wave_q <= {OUT_W{1'b0}};
    end else begin
      acc_q  <= acc_d;
      sync_q <= sync_d;
      wave_q <= wave_d;
    end
  end

  assign msb_out  = acc_q[ACC_W-1];
  assign sync_out = sync_q;
  assign wave_out = wave_q;

endmodule

// File: tb/tb_sid_voice_osc.sv
// Self-checking bench for sid_voice_osc: directed steps plus random stimulus
// compared against an arithmetic reference model of the oscillator.
module tb_sid_voice_osc;

  localparam logic [22:0] SEED = 23'h7FFFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [15:0] freq = 16'h0000;
  logic [11:0] pw = 12'h000;
  logic [3:0]  wave_sel = 4'h0;
  logic        test = 1'b0;
  logic        sync_en = 1'b0;
  logic        ring_en = 1'b0;
  logic        sync_in = 1'b0;
  logic        ring_in = 1'b0;
  logic        sync_out;
  logic        msb_out;
  logic [11:0] wave_out;

  int checks = 0;
  int errors = 0;

  int unsigned m_acc = 0;
  logic [22:0] m_lfsr = SEED;
  logic        m_sync = 1'b0;
  logic [11:0] m_wave = 12'h000;

  sid_voice_osc dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .freq     (freq),
    .pw       (pw),
    .wave_sel (wave_sel),
    .test     (test),
    .sync_en  (sync_en),
    .ring_en  (ring_en),
    .sync_in  (sync_in),
    .ring_in  (ring_in),
    .sync_out (sync_out),
    .msb_out  (msb_out),
    .wave_out (wave_out)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_acc  = 0;
    m_lfsr = SEED;
    m_sync = 1'b0;
    m_wave = 12'h000;
  endfunction

  function automatic void model_tick();
    int unsigned old_acc, new_acc, idx, flip, tri_v, saw_v, pul_v, noi_v;
    logic [7:0]  nb;
    if (!tick) return;
    old_acc = m_acc;
    if (test) new_acc = 0;
    else if (sync_en && sync_in) new_acc = 0;
    else new_acc = (old_acc + freq) % (1 << 24);
    m_sync = (new_acc >= (1 << 23)) && (old_acc < (1 << 23));
    if (test) m_lfsr = SEED;
    else if (((new_acc >> 19) & 1) == 1 && ((old_acc >> 19) & 1) == 0)
      m_lfsr = {m_lfsr[21:0], m_lfsr[22] ^ m_lfsr[17]};
    m_acc = new_acc;
    saw_v = new_acc >> 12;
    idx   = (new_acc >> 11) % 4096;
    flip  = (new_acc >> 23) ^ ((ring_en && ring_in) ? 1 : 0);
    tri_v = (flip != 0) ? (4095 - idx) : idx;
    pul_v = (test || (new_acc >> 12) >= pw) ? 4095 : 0;
    nb    = {m_lfsr[22], m_lfsr[20], m_lfsr[16], m_lfsr[13],
             m_lfsr[11], m_lfsr[7], m_lfsr[4], m_lfsr[2]};
    noi_v = int'(nb) * 16;
`ifdef SID_OSC_COMBINED_EN
    begin
      int unsigned acc_and;
      acc_and = 4095;
      if (wave_sel[3]) acc_and &= noi_v;
      if (wave_sel[2]) acc_and &= pul_v;
      if (wave_sel[1]) acc_and &= saw_v;
      if (wave_sel[0]) acc_and &= tri_v;
      if (wave_sel == 4'h0) acc_and = 0;
      m_wave = acc_and[11:0];
    end
`else
    if (wave_sel[3]) m_wave = noi_v[11:0];
    else if (wave_sel[2]) m_wave = pul_v[11:0];
    else if (wave_sel[1]) m_wave = saw_v[11:0];
    else if (wave_sel[0]) m_wave = tri_v[11:0];
    else m_wave = 12'h000;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_tick();
    chk("wave", {20'd0, wave_out}, {20'd0, m_wave});
    chk("sync", {31'd0, sync_out}, {31'd0, m_sync});
    chk("msb",  {31'd0, msb_out}, m_acc >> 23);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_wave", {20'd0, wave_out}, 32'd0);
    chk("rst_sync", {31'd0, sync_out}, 32'd0);
    chk("rst_msb",  {31'd0, msb_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [11:0] held;
    logic [11:0] e0;

    // Saw ramp and wrap
    do_reset();
    tick = 1'b1; freq = 16'h1000; wave_sel = 4'b0010;
    for (int n = 1; n <= 4096; n++) begin
      step();
      chk("saw_n", {20'd0, wave_out}, n % 4096);
      if (n == 4096) chk("saw_wrap_sync", {31'd0, sync_out}, 32'd0);
    end

    // Triangle and sync_out timing
    do_reset();
    wave_sel = 4'b0001;
    for (int n = 1; n <= 4096; n++) begin
      step();
      chk("tri_sync", {31'd0, sync_out}, (n == 2048) ? 32'd1 : 32'd0);
      if (n == 1024) chk("tri_1024", {20'd0, wave_out}, 32'h800);
      if (n == 3072) chk("tri_3072", {20'd0, wave_out}, 32'h7FF);
    end

    // Pulse threshold then test hold
    do_reset();
    wave_sel = 4'b0100; pw = 12'h800;
    for (int n = 1; n <= 4095; n++) begin
      step();
      chk("pulse", {20'd0, wave_out}, (n >= 2048) ? 32'hFFF : 32'h0);
    end
    test = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("pulse_test", {20'd0, wave_out}, 32'hFFF);
      chk("test_msb", {31'd0, msb_out}, 32'd0);
    end
    test = 1'b0;

    // Hard sync and ring modulation
    do_reset();
    freq = 16'h0100; wave_sel = 4'b0010; sync_en = 1'b1; sync_in = 1'b0;
    for (int n = 0; n < 300; n++) step();
    sync_in = 1'b1;
    step();
    chk("sync_zero", {20'd0, wave_out}, 32'd0);
    sync_in = 1'b0; sync_en = 1'b0;
    for (int n = 0; n < 700; n++) step();
    freq = 16'h0000; wave_sel = 4'b0001; ring_en = 1'b1; ring_in = 1'b0;
    step();
    e0 = m_wave;
    ring_in = 1'b1;
    step();
    chk("ring_inv", {20'd0, wave_out}, {20'd0, ~e0});
    ring_en = 1'b0; ring_in = 1'b0;

    // Noise from seed after test
    do_reset();
    freq = 16'h8000; wave_sel = 4'b1000; test = 1'b1;
    step();
    chk("noise_seed", {20'd0, wave_out}, 32'hFE0);
    test = 1'b0;
    for (int n = 0; n < 1200; n++) step();

    // Randomised operation against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tick     = ($urandom_range(0, 3) != 0);
      freq     = 16'($urandom);
      pw       = 12'($urandom);
      wave_sel = 4'($urandom);
      test     = ($urandom_range(0, 31) == 0);
      sync_en  = 1'($urandom);
      sync_in  = ($urandom_range(0, 15) == 0);
      ring_en  = 1'($urandom);
      ring_in  = 1'($urandom);
      step();
    end

    // Mid-ramp async reset, tick gating, clean restart
    test = 1'b0; sync_en = 1'b0; sync_in = 1'b0; ring_en = 1'b0; ring_in = 1'b0;
    do_reset();
    tick = 1'b1; freq = 16'h1000; wave_sel = 4'b0010;
    for (int n = 0; n < 500; n++) step();
    held = m_wave;
    tick = 1'b0;
    for (int n = 0; n < 100; n++) begin
      freq = 16'($urandom); test = 1'($urandom); sync_en = 1'b1; sync_in = 1'($urandom);
      step();
      chk("gate_hold", {20'd0, wave_out}, {20'd0, held});
    end
    test = 1'b0; sync_en = 1'b0; sync_in = 1'b0; freq = 16'h1000;
    do_reset();
    tick = 1'b1;
    step();
    chk("restart_1", {20'd0, wave_out}, 32'd1);
    step();
    chk("restart_2", {20'd0, wave_out}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
